vertex_draw_sequencer: RTL
==========================

// Module: vertex_draw_sequencer
// PURPOSE
//  Sequences one draw command (base address, first index, vertex count) into per-vertex
//  start/done fetches on the vertex fetch unit, one vertex in flight at a time.
//  Forwards each fetched vertex downstream (primitive assembly) over a valid/ready stream
//  with ordinal and last flag. Sits between the command front-end and the vertex fetch unit.
// PARAMETERS
//  ADDR_WIDTH   32   vertex array byte address width (matches fetch unit)
//  VDATA_WIDTH  256  vertex payload width (ATTR_WIDTH*ATTRS_PER_VERTEX of fetch unit)
//  INDEX_WIDTH  16   vertex index width (matches fetch unit i_vertex_index)
//  COUNT_WIDTH  16   vertex count / ordinal width
//  STALL_WIDTH  16   downstream-stall counter width
// PORTS
//  clk                 in   1            clock; single domain
//  rst                 in   1            synchronous, active-high reset
//  i_draw_valid        in   1            draw command valid
//  o_draw_ready        out  1            command accepted when valid&&ready
//  i_draw_base_addr    in   ADDR_WIDTH   vertex array base address
//  i_draw_first_index  in   INDEX_WIDTH  first vertex index
//  i_draw_count        in   COUNT_WIDTH  vertices to fetch (0 legal)
//  o_busy              out  1            high whenever state != IDLE
//  o_draw_done         out  1            1-cycle pulse when draw completes
//  o_fetch_start       out  1            1-cycle start pulse to fetch unit
//  o_fetch_base_addr   out  ADDR_WIDTH   latched base address
//  o_fetch_index       out  INDEX_WIDTH  index of vertex being fetched
//  i_fetch_done        in   1            fetch unit done pulse; i_fetch_data valid this cycle
//  i_fetch_data        in   VDATA_WIDTH  fetched vertex payload
//  o_vtx_valid         out  1            downstream vertex valid
//  i_vtx_ready         in   1            downstream ready
//  o_vtx_data          out  VDATA_WIDTH  vertex payload
//  o_vtx_id            out  COUNT_WIDTH  ordinal within draw, 0..count-1
//  o_vtx_last          out  1            high with final vertex of draw
//  o_stall_cycles      out  STALL_WIDTH  cycles in EMIT with i_vtx_ready low, saturating
// BEHAVIOUR
//  - States: IDLE, START, WAIT, EMIT, DONE. All outputs decoded from registered state/regs.
//  - Reset (rst high at edge): state=IDLE, ordinal n=0, data/addr/index regs=0, stall=0.
//    After reset: draw_ready=1; fetch_start/vtx_valid/draw_done/busy=0. draw_ready is 0 while rst high.
//  - IDLE: draw_ready=1. On valid&&ready latch base, first, count; clear n and o_stall_cycles.
//    count==0 -> DONE (no fetch); else -> START. Accept at edge T => fetch_start high in cycle T+1.
//  - START: fetch_start=1 for exactly one cycle; fetch_index = first+n mod 2^INDEX_WIDTH -> WAIT.
//  - WAIT: fetch_base_addr/fetch_index held stable. On i_fetch_done capture i_fetch_data -> EMIT.
//  - EMIT: vtx_valid=1; data/id/last held stable until handshake; last = (n==count-1).
//    On i_vtx_ready: if last -> DONE else n<=n+1 -> START. Each ready-low cycle: stall+1, saturating at all-ones.
//  - DONE: draw_done=1 for one cycle -> IDLE. Back-to-back draws: next accept in the following cycle.
//  - i_fetch_done outside WAIT is ignored. Draw commands while busy are not accepted.
//  - At most one fetch outstanding; exactly count fetch_start pulses and count vertices per draw.
//  - o_vtx_id = n (COUNT_WIDTH). Index add truncates silently; no address check (fetch unit owns stride).
//  - Reset mid-draw: immediate abort to IDLE, no draw_done, no vertex emitted. A late fetch_done
//    from the fetch unit is ignored. The fetch unit must be reset in the same cycle.
// TESTING
//  1. base=0x1000, first=5, count=3, 2-cycle fetch model, ready=1 -> indices 5,6,7; ids 0,1,2; last only on id 2; one draw_done.
//  2. count=0 -> no fetch_start; draw_done in cycle T+1 after accept; draw_ready=1 at T+2.
//  3. count=2, ready low 5 cycles on id 0 -> valid/data held, no fetch_start in between, o_stall_cycles=5.
//  4. first=0xFFFE, count=3 -> fetch_index 0xFFFE, 0xFFFF, 0x0000; ids 0,1,2.
//  5. rst for 1 cycle in WAIT, then fetch_done -> no vtx_valid, no draw_done; a new draw completes normally.
//  6. draw_valid held during busy draw -> draw_ready=0; second draw accepted the cycle after draw_done.

Source files
------------

// File: rtl/vertex_draw_sequencer.sv
// Vertex draw sequencer: walks one draw command through the vertex fetch unit,
// one vertex in flight at a time, and streams each fetched vertex downstream
// with its ordinal and a last-of-draw flag.
module vertex_draw_sequencer #(
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned VDATA_WIDTH = 256,
    parameter int unsigned INDEX_WIDTH = 16,
    parameter int unsigned COUNT_WIDTH = 16,
    parameter int unsigned STALL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_draw_valid,
    output logic                   o_draw_ready,
    input  logic [ADDR_WIDTH-1:0]  i_draw_base_addr,
    input  logic [INDEX_WIDTH-1:0] i_draw_first_index,
    input  logic [COUNT_WIDTH-1:0] i_draw_count,
    output logic                   o_busy,
    output logic                   o_draw_done,
    output logic                   o_fetch_start,
    output logic [ADDR_WIDTH-1:0]  o_fetch_base_addr,
    output logic [INDEX_WIDTH-1:0] o_fetch_index,
    input  logic                   i_fetch_done,
    input  logic [VDATA_WIDTH-1:0] i_fetch_data,
    output logic                   o_vtx_valid,
    input  logic                   i_vtx_ready,
    output logic [VDATA_WIDTH-1:0] o_vtx_data,
    output logic [COUNT_WIDTH-1:0] o_vtx_id,
    output logic                   o_vtx_last,
    output logic [STALL_WIDTH-1:0] o_stall_cycles
);

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_START = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_EMIT  = 3'd3;
    localparam logic [2:0] ST_DONE  = 3'd4;

    logic [2:0]             state;
    logic [2:0]             state_nxt;
    logic [ADDR_WIDTH-1:0]  base_q;
    logic [INDEX_WIDTH-1:0] first_q;
    logic [COUNT_WIDTH-1:0] count_q;
    logic [COUNT_WIDTH-1:0] n_q;
    logic [VDATA_WIDTH-1:0] data_q;
    logic [STALL_WIDTH-1:0] stall_q;
    logic                   accept_c;
    logic                   last_c;

    assign accept_c = (state == ST_IDLE) && i_draw_valid;
    assign last_c   = (n_q == (count_q - COUNT_WIDTH'(1)));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_draw_valid) begin
                    state_nxt = (i_draw_count == '0) ? ST_DONE : ST_START;
                end
            end
            ST_START: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (i_fetch_done) begin
                    state_nxt = ST_EMIT;
                end
            end
            ST_EMIT: begin
                if (i_vtx_ready) begin
                    state_nxt = last_c ? ST_DONE : ST_START;
                end
            end
            ST_DONE: state_nxt = ST_IDLE;
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Command latch, ordinal, vertex capture and stall counter
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q  <= '0;
            first_q <= '0;
            count_q <= '0;
            n_q     <= '0;
            data_q  <= '0;
            stall_q <= '0;
        end else begin
            if (accept_c) begin
                base_q  <= i_draw_base_addr;
                first_q <= i_draw_first_index;
                count_q <= i_draw_count;
                n_q     <= '0;
                stall_q <= '0;
            end
            if ((state == ST_WAIT) && i_fetch_done) begin
                data_q <= i_fetch_data;
            end
            if (state == ST_EMIT) begin
                if (i_vtx_ready) begin
                    if (!last_c) begin
                        n_q <= n_q + COUNT_WIDTH'(1);
                    end
                end else if (stall_q != '1) begin
                    stall_q <= stall_q + STALL_WIDTH'(1);
                end
            end
        end
    end

    // Outputs decoded from registered state and datapath registers
    assign o_draw_ready      = (state == ST_IDLE) && !rst;
    assign o_busy            = (state != ST_IDLE);
    assign o_draw_done       = (state == ST_DONE);
    assign o_fetch_start     = (state == ST_START);
    assign o_fetch_base_addr = base_q;
    assign o_fetch_index     = first_q + INDEX_WIDTH'(n_q);
    assign o_vtx_valid       = (state == ST_EMIT);
    assign o_vtx_data        = data_q;
    assign o_vtx_id          = n_q;
    assign o_vtx_last        = (state == ST_EMIT) && last_c;
    assign o_stall_cycles    = stall_q;

endmodule
